// File: rtl/mcb_port_pkg.sv
// Shared definitions for the mcb_port_model memory-side responder: command codes,
// executor state encoding and the byte-lane merge helper.
package mcb_port_pkg;

  localparam logic [2:0] CMD_WRITE    = 3'b000;
  localparam logic [2:0] CMD_READ     = 3'b001;
  localparam logic [2:0] CMD_WRITE_PC = 3'b010;
  localparam logic [2:0] CMD_READ_PC  = 3'b011;
  localparam logic [2:0] CMD_REFRESH  = 3'b100;

  localparam int DATA_FIFO_DEPTH = 64;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_READ_WAIT = 3'd2,
    ST_READ      = 3'd3,
    ST_REFRESH   = 3'd4
  } exec_state_e;

  // A set keep bit preserves that byte lane of the old word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  keep);
    logic [31:0] result;
    for (int i = 0; i < 4; i++) begin
      result[8*i +: 8] = keep[i] ? old_word[8*i +: 8] : new_word[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/mcb_port_model_if.sv
// User-port bundle between the DDR3 controller (master) and the memory-side
// responder (slave).
interface mcb_port_model_if;

  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [27:0] cmd_word_addr;
  logic        cmd_empty;
  logic        cmd_full;

  logic        wr_en;
  logic [3:0]  wr_mask;
  logic [31:0] wr_data;
  logic        wr_full;
  logic        wr_empty;
  logic [6:0]  wr_count;
  logic        wr_underrun;
  logic        wr_error;

  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_full;
  logic        rd_empty;
  logic [6:0]  rd_count;
  logic        rd_overflow;
  logic        rd_error;

  modport master (
    output cmd_en, cmd_instr, cmd_bl, cmd_word_addr,
    output wr_en, wr_mask, wr_data,
    output rd_en,
    input  cmd_empty, cmd_full,
    input  wr_full, wr_empty, wr_count, wr_underrun, wr_error,
    input  rd_data, rd_full, rd_empty, rd_count, rd_overflow, rd_error
  );

  modport slave (
    input  cmd_en, cmd_instr, cmd_bl, cmd_word_addr,
    input  wr_en, wr_mask, wr_data,
    input  rd_en,
    output cmd_empty, cmd_full,
    output wr_full, wr_empty, wr_count, wr_underrun, wr_error,
    output rd_data, rd_full, rd_empty, rd_count, rd_overflow, rd_error
  );

endinterface

// File: rtl/mcb_port_fifo.sv
// Single-clock show-ahead FIFO with registered count/full/empty. A push while full
// is accepted when a pop happens on the same edge; rejected strobes are reported.
module mcb_port_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             push_drop,
  output logic             pop_err
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;
  logic             full_r;
  logic             empty_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Accept decisions and next occupancy.
  always_comb begin
    pop_ok_s  = pop & ~empty_r;
    push_ok_s = push & (~full_r | pop_ok_s);
    push_drop = push & ~push_ok_s;
    pop_err   = pop & empty_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage array; contents need no reset since empty gates the head.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and registered status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CW'(DEPTH));
      empty_r <= (count_nxt_s == {CW{1'b0}});
    end
  end

  assign dout  = empty_r ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = full_r;
  assign empty = empty_r;

endmodule

// File: rtl/mcb_port_model.sv
// Memory-side responder for the MCB user port: command/write/read FIFOs, an executor
// FSM and a word-addressed RAM. Define MCB_PORT_WR_MASK_EN to honour wr_mask byte lanes.
module mcb_port_model
  import mcb_port_pkg::*;
#(
  parameter int MEM_AW         = 10,
  parameter int CMD_DEPTH      = 4,
  parameter int READ_LATENCY   = 4,
  parameter int REFRESH_CYCLES = 8
) (
  input logic            clk,
  input logic            rst,
  mcb_port_model_if.slave port
);

`ifdef MCB_PORT_WR_MASK_EN
  localparam int WR_W = 36;
`else
  localparam int WR_W = 32;
`endif
  localparam int CMD_W = 37;
  localparam int CMD_CW = $clog2(CMD_DEPTH) + 1;

  logic [CMD_W-1:0]  cmd_head_s;
  logic [CMD_CW-1:0] cmd_count_s;
  logic              cmd_empty_s;
  logic              cmd_pop_s;
  logic              cmd_drop_s;
  logic              cmd_pop_err_s;

  logic [WR_W-1:0]   wr_din_s;
  logic [WR_W-1:0]   wr_head_s;
  logic              wr_empty_s;
  logic              wr_pop_s;
  logic              wr_drop_s;
  logic              wr_underrun_s;

  logic              rd_push_s;
  logic              rd_overflow_s;
  logic              rd_pop_err_s;
  logic              rd_drop_unused_s;

  logic [31:0]       ram_r [2**MEM_AW];
  logic [MEM_AW-1:0] addr_r;
  logic [5:0]        beat_r;
  logic [15:0]       wait_r;
  exec_state_e       state_r;

  logic              ram_we_s;
  logic [31:0]       wdata_s;
  logic [3:0]        wmask_s;

  logic              wr_underrun_r;
  logic              wr_error_r;
  logic              rd_overflow_r;
  logic              rd_error_r;

`ifdef MCB_PORT_WR_MASK_EN
  assign wr_din_s = {port.wr_mask, port.wr_data};
`else
  assign wr_din_s = port.wr_data;
`endif

  mcb_port_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (port.cmd_en),
    .din       ({port.cmd_instr, port.cmd_bl, port.cmd_word_addr}),
    .pop       (cmd_pop_s),
    .dout      (cmd_head_s),
    .count     (cmd_count_s),
    .full      (port.cmd_full),
    .empty     (cmd_empty_s),
    .push_drop (cmd_drop_s),
    .pop_err   (cmd_pop_err_s)
  );

  mcb_port_fifo #(.WIDTH(WR_W), .DEPTH(DATA_FIFO_DEPTH)) u_wr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (port.wr_en),
    .din       (wr_din_s),
    .pop       (wr_pop_s),
    .dout      (wr_head_s),
    .count     (port.wr_count),
    .full      (port.wr_full),
    .empty     (wr_empty_s),
    .push_drop (wr_drop_s),
    .pop_err   (wr_underrun_s)
  );

  mcb_port_fifo #(.WIDTH(32), .DEPTH(DATA_FIFO_DEPTH)) u_rd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_push_s),
    .din       (ram_r[addr_r]),
    .pop       (port.rd_en),
    .dout      (port.rd_data),
    .count     (port.rd_count),
    .full      (port.rd_full),
    .empty     (port.rd_empty),
    .push_drop (rd_overflow_s),
    .pop_err   (rd_pop_err_s)
  );

  assign rd_drop_unused_s = 1'b0;

  // Executor strobes; an empty write FIFO substitutes a zero word with all lanes enabled.
  always_comb begin
    cmd_pop_s = (state_r == ST_IDLE) & ~cmd_empty_s;
    wr_pop_s  = (state_r == ST_WRITE);
    ram_we_s  = (state_r == ST_WRITE);
    rd_push_s = (state_r == ST_READ);
    if (wr_empty_s) begin
      wdata_s = 32'h0000_0000;
      wmask_s = 4'b0000;
    end else begin
`ifdef MCB_PORT_WR_MASK_EN
      wdata_s = wr_head_s[31:0];
      wmask_s = wr_head_s[35:32];
`else
      wdata_s = wr_head_s;
      wmask_s = 4'b0000;
`endif
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      ram_r[addr_r] <= merge_bytes(ram_r[addr_r], wdata_s, wmask_s);
    end
  end

  // Executor FSM: one IDLE cycle separates consecutive commands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      addr_r  <= {MEM_AW{1'b0}};
      beat_r  <= 6'd0;
      wait_r  <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!cmd_empty_s) begin
            addr_r <= cmd_head_s[MEM_AW-1:0];
            beat_r <= cmd_head_s[33:28];
            wait_r <= 16'd0;
            case (cmd_head_s[36:34])
              CMD_WRITE, CMD_WRITE_PC: state_r <= ST_WRITE;
              CMD_READ, CMD_READ_PC:   state_r <= ST_READ_WAIT;
              CMD_REFRESH:             state_r <= ST_REFRESH;
              default:                 state_r <= ST_IDLE;
            endcase
          end
        end
        ST_WRITE, ST_READ: begin
          addr_r <= addr_r + MEM_AW'(1);
          if (beat_r == 6'd0) begin
            state_r <= ST_IDLE;
          end else begin
            beat_r <= beat_r - 6'd1;
          end
        end
        ST_READ_WAIT: begin
          if (wait_r == 16'(READ_LATENCY - 1)) begin
            state_r <= ST_READ;
          end else begin
            wait_r <= wait_r + 16'd1;
          end
        end
        ST_REFRESH: begin
          if (wait_r == 16'(REFRESH_CYCLES - 1)) begin
            state_r <= ST_IDLE;
          end else begin
            wait_r <= wait_r + 16'd1;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_underrun_r <= 1'b0;
      wr_error_r    <= 1'b0;
      rd_overflow_r <= 1'b0;
      rd_error_r    <= 1'b0;
    end else begin
      if (wr_underrun_s) begin
        wr_underrun_r <= 1'b1;
      end
      if (cmd_drop_s | wr_drop_s) begin
        wr_error_r <= 1'b1;
      end
      if (rd_overflow_s) begin
        rd_overflow_r <= 1'b1;
      end
      if (rd_pop_err_s) begin
        rd_error_r <= 1'b1;
      end
    end
  end

  assign port.cmd_empty   = cmd_empty_s;
  assign port.wr_empty    = wr_empty_s;
  assign port.wr_underrun = wr_underrun_r;
  assign port.wr_error    = wr_error_r;
  assign port.rd_overflow = rd_overflow_r;
  assign port.rd_error    = rd_error_r;

endmodule

// File: tb/tb_mcb_port_model.sv
// Directed bench for mcb_port_model: write/read-back, latency, underrun and wrap,
// byte mask (MCB_PORT_WR_MASK_EN), error flags, overflow and reset mid-read.
module tb_mcb_port_model;
  import mcb_port_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  mcb_port_model_if bus ();

  mcb_port_model #(
    .MEM_AW(10), .CMD_DEPTH(4), .READ_LATENCY(4), .REFRESH_CYCLES(8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .port (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [2:0] instr, input logic [5:0] bl, input logic [27:0] addr);
    bus.cmd_en        = 1'b1;
    bus.cmd_instr     = instr;
    bus.cmd_bl        = bl;
    bus.cmd_word_addr = addr;
    tick();
    bus.cmd_en        = 1'b0;
  endtask

  task automatic push_wr(input logic [31:0] d, input logic [3:0] m);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    bus.wr_mask = m;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] exp);
    chk(tag, bus.rd_data, exp);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(bus.cmd_empty && dut.state_r == ST_IDLE) && n < 400) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < 400), 32'd1);
  endtask

  task automatic wait_rd(input int target, input string tag);
    int n = 0;
    while (int'(bus.rd_count) != target && n < 400) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.rd_count), 32'(target));
  endtask

  initial begin
    logic [31:0] mask_exp;
    vectors     = 0;
    miscompares = 0;
    rst               = 1'b1;
    bus.cmd_en        = 1'b0;
    bus.cmd_instr     = 3'b000;
    bus.cmd_bl        = 6'd0;
    bus.cmd_word_addr = 28'd0;
    bus.wr_en         = 1'b0;
    bus.wr_mask       = 4'b0000;
    bus.wr_data       = 32'd0;
    bus.rd_en         = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_cmd_empty", 32'(bus.cmd_empty), 32'd1);
    chk("rst_wr_empty", 32'(bus.wr_empty), 32'd1);
    chk("rst_rd_empty", 32'(bus.rd_empty), 32'd1);
    chk("rst_fulls", 32'({bus.cmd_full, bus.wr_full, bus.rd_full}), 32'd0);
    chk("rst_counts", 32'({bus.wr_count, bus.rd_count}), 32'd0);
    chk("rst_sticky", 32'({bus.wr_underrun, bus.wr_error, bus.rd_overflow, bus.rd_error}), 32'd0);
    chk("rst_rd_data", bus.rd_data, 32'd0);
    rst = 1'b0;
    tick();

    // Write then read back, back-to-back commands
    push_wr(32'h1111_1111, 4'b0000);
    push_wr(32'h2222_2222, 4'b0000);
    push_wr(32'h3333_3333, 4'b0000);
    push_wr(32'h4444_4444, 4'b0000);
    chk("wr_count4", 32'(bus.wr_count), 32'd4);
    send_cmd(CMD_WRITE, 6'd3, 28'h10);
    send_cmd(CMD_READ, 6'd3, 28'h10);
    wait_rd(4, "wb_rd_count");
    chk("wb_wr_empty", 32'(bus.wr_empty), 32'd1);
    pop_chk("wb_w0", 32'h1111_1111);
    pop_chk("wb_w1", 32'h2222_2222);
    pop_chk("wb_w2", 32'h3333_3333);
    pop_chk("wb_w3", 32'h4444_4444);
    chk("wb_rd_empty", 32'(bus.rd_empty), 32'd1);
    wait_idle("wb_idle");

    // Read latency: strobe at N, first word visible at N+7
    send_cmd(CMD_READ, 6'd0, 28'h10);
    repeat (5) tick();
    chk("lat_n6_empty", 32'(bus.rd_empty), 32'd1);
    tick();
    chk("lat_n7_empty", 32'(bus.rd_empty), 32'd0);
    pop_chk("lat_word", 32'h1111_1111);
    wait_idle("lat_idle");

    // Underrun and address wrap (upper address bits ignored)
    push_wr(32'hDEAD_BEEF, 4'b0000);
    push_wr(32'hCAFE_F00D, 4'b0000);
    send_cmd(CMD_WRITE, 6'd1, 28'h000_03FF);
    wait_idle("ur_pre_idle");
    chk("ur_pre_flag", 32'(bus.wr_underrun), 32'd0);
    chk("ur_pre_wr_empty", 32'(bus.wr_empty), 32'd1);
    send_cmd(CMD_WRITE_PC, 6'd1, 28'h000_0BFF);
    wait_idle("ur_idle");
    chk("ur_flag", 32'(bus.wr_underrun), 32'd1);
    send_cmd(CMD_READ_PC, 6'd1, 28'h3FF);
    wait_rd(2, "ur_rd_count");
    pop_chk("ur_ram3ff", 32'h0000_0000);
    pop_chk("ur_ram000", 32'h0000_0000);
    wait_idle("ur_rd_idle");

    // Byte mask
`ifdef MCB_PORT_WR_MASK_EN
    mask_exp = 32'h11BB_33DD;
`else
    mask_exp = 32'h1122_3344;
`endif
    push_wr(32'hAABB_CCDD, 4'b0000);
    push_wr(32'h1122_3344, 4'b0101);
    send_cmd(CMD_WRITE, 6'd0, 28'h20);
    send_cmd(CMD_WRITE, 6'd0, 28'h20);
    send_cmd(CMD_READ, 6'd0, 28'h20);
    wait_rd(1, "mask_rd_count");
    pop_chk("mask_word", mask_exp);
    wait_idle("mask_idle");

    // Undefined instruction is discarded
    send_cmd(3'b111, 6'd5, 28'h10);
    wait_idle("inv_idle");
    chk("inv_counts", 32'({bus.wr_count, bus.rd_count}), 32'd0);

    // Pop on empty read FIFO
    chk("rderr_pre", 32'(bus.rd_error), 32'd0);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk("rderr_flag", 32'(bus.rd_error), 32'd1);
    chk("rderr_count", 32'(bus.rd_count), 32'd0);

    // Command FIFO full while a refresh occupies the executor
    send_cmd(CMD_REFRESH, 6'd0, 28'h0);
    for (int i = 0; i < 4; i++) begin
      send_cmd(CMD_REFRESH, 6'd0, 28'h0);
    end
    chk("cf_full", 32'(bus.cmd_full), 32'd1);
    chk("cf_err_pre", 32'(bus.wr_error), 32'd0);
    send_cmd(CMD_REFRESH, 6'd0, 28'h0);
    chk("cf_err", 32'(bus.wr_error), 32'd1);
    wait_idle("cf_idle");
    chk("cf_empty", 32'(bus.cmd_empty), 32'd1);

    // Read overflow
    send_cmd(CMD_READ, 6'd63, 28'h10);
    wait_idle("ov1_idle");
    chk("ov1_count", 32'(bus.rd_count), 32'd64);
    chk("ov1_full", 32'(bus.rd_full), 32'd1);
    chk("ov1_flag", 32'(bus.rd_overflow), 32'd0);
    send_cmd(CMD_READ, 6'd63, 28'h10);
    wait_idle("ov2_idle");
    chk("ov2_count", 32'(bus.rd_count), 32'd64);
    chk("ov2_full", 32'(bus.rd_full), 32'd1);
    chk("ov2_flag", 32'(bus.rd_overflow), 32'd1);
    chk("ov2_head", bus.rd_data, 32'h1111_1111);

    // Drain the read FIFO
    pop_chk("dr_w0", 32'h1111_1111);
    chk("dr_not_full", 32'(bus.rd_full), 32'd0);
    pop_chk("dr_w1", 32'h2222_2222);
    pop_chk("dr_w2", 32'h3333_3333);
    pop_chk("dr_w3", 32'h4444_4444);
    bus.rd_en = 1'b1;
    repeat (60) tick();
    bus.rd_en = 1'b0;
    chk("dr_empty", 32'(bus.rd_empty), 32'd1);

    // Reset mid-read
    send_cmd(CMD_READ, 6'd63, 28'h10);
    wait_rd(10, "mr_count10");
    chk("mr_in_read", 32'(dut.state_r == ST_READ), 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_counts", 32'({bus.wr_count, bus.rd_count}), 32'd0);
    chk("mr_empties", 32'({bus.cmd_empty, bus.wr_empty, bus.rd_empty}), 32'd7);
    chk("mr_state", 32'(dut.state_r == ST_IDLE), 32'd1);
    chk("mr_sticky", 32'({bus.wr_underrun, bus.wr_error, bus.rd_overflow, bus.rd_error}), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    send_cmd(CMD_READ, 6'd3, 28'h10);
    wait_rd(4, "pr_rd_count");
    pop_chk("pr_w0", 32'h1111_1111);
    pop_chk("pr_w1", 32'h2222_2222);
    pop_chk("pr_w2", 32'h3333_3333);
    pop_chk("pr_w3", 32'h4444_4444);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mcb_port_model.md
# mcb_port_model

Single-clock, synthesizable responder for the memory-controller user port: it is the memory side of the `cmd_*`/`wr_*`/`rd_*` handshake that our DDR3 controller drives. It buffers commands and write data, executes them against an internal word-addressed RAM, and returns read data through a show-ahead read FIFO. It serves as the DDR3/MCB stand-in on simulation benches and on FPGA builds without external memory.

## Interface
- `MEM_AW`, 10: RAM address width in 32-bit words. The RAM holds 2^MEM_AW words.
- `CMD_DEPTH`, 4: command FIFO entries. Must be a power of two.
- `READ_LATENCY`, 4: idle cycles between a read command starting execution and its first word push.
- `REFRESH_CYCLES`, 8: busy cycles consumed by a refresh command.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `cmd_en` in 1: command strobe.
- `cmd_instr` in 3: 000 write, 001 read, 010 write-PC, 011 read-PC, 100 refresh.
- `cmd_bl` in 6: burst length minus 1 (1..64 words).
- `cmd_word_addr` in 28: starting word address.
- `cmd_empty` out 1: command FIFO empty.
- `cmd_full` out 1: command FIFO full.
- `wr_en` in 1: write-data strobe.
- `wr_mask` in 4: byte mask; 1 = do not write that byte lane.
- `wr_data` in 32: write data.
- `wr_full`, `wr_empty` out 1: write FIFO status.
- `wr_count` out 7: write FIFO occupancy, 0..64.
- `wr_underrun` out 1: sticky.
- `wr_error` out 1: sticky.
- `rd_en` in 1: read-data pop.
- `rd_data` out 32: head of the read FIFO; valid whenever `rd_empty`=0.
- `rd_full`, `rd_empty` out 1: read FIFO status.
- `rd_count` out 7: read FIFO occupancy, 0..64.
- `rd_overflow` out 1: sticky.
- `rd_error` out 1: sticky.

## Operation
- Three FIFOs:
  - Command FIFO: CMD_DEPTH × 37 bits, holding instr, bl and addr.
  - Write FIFO: 64 × 36 bits, holding data and mask.
  - Read FIFO: 64 × 32 bits, show-ahead.
- `cmd_en` with `cmd_full`=1: the command is dropped and `wr_error` is set.
- `wr_en` with `wr_full`=1: the word is dropped and `wr_error` is set.
- `rd_en` with `rd_empty`=1: no pop occurs and `rd_error` is set.
- Executor FSM:
  - IDLE: if the command FIFO is not empty, pop the command and latch addr, bl and instr. Instr 000/010 goes to WRITE, 001/011 to READ_WAIT, 100 to REFRESH. Any other code is popped and discarded, and the FSM stays in IDLE.
  - WRITE: one word per cycle for bl+1 cycles. Pop the write FIFO and write to RAM[addr]. If the write FIFO is empty, write 32'h0 with mask 0, set `wr_underrun`, and continue. Return to IDLE after the last word.
  - READ_WAIT: count READ_LATENCY cycles, then go to READ.
  - READ: push RAM[addr] to the read FIFO, one word per cycle for bl+1 cycles. If the read FIFO is full, drop the word, set `rd_overflow`, and continue. Return to IDLE.
  - REFRESH: count REFRESH_CYCLES, then return to IDLE.
- Address arithmetic:
  - RAM index = `cmd_word_addr[MEM_AW-1:0]`; upper bits are ignored.
  - The index increments by 1 per word and wraps modulo 2^MEM_AW.
- Precharge variants (010/011) behave the same as 000/001.
- Sticky flags clear only on `rst`.

## Timing
- Reset values:
  - `cmd_empty`=1, `wr_empty`=1, `rd_empty`=1.
  - `cmd_full`=0, `wr_full`=0, `rd_full`=0.
  - `wr_count`=0, `rd_count`=0.
  - All sticky flags 0; `rd_data`=0.
  - FSM in IDLE; RAM contents are not reset.
- FIFO status outputs are registered and reflect strobes on the next cycle. Simultaneous push and pop leaves the count unchanged. Push and pop on the same cycle at count 0 or 64 is legal: at 64 it is a pop plus an accepted push; at 0 the push is accepted and the pop is an error.
- Command accept to execution start:
  - A command strobed at cycle N is popped in IDLE no earlier than N+1.
  - The first write-RAM update occurs at N+2.
  - The first read word is visible (`rd_empty`=0) at N+2+READ_LATENCY+1.
- Back-to-back commands: the FSM passes through IDLE for exactly one cycle between commands.
- `rd_data` is combinational from the read-FIFO head; `rd_en` pops at the clock edge.
- Asserting `rst` mid-burst aborts immediately. All FIFOs are flushed, and the RAM keeps the words already written.

## Configuration
- `MCB_PORT_WR_MASK_EN`:
  - Defined: each byte lane whose `wr_mask` bit is 1 keeps its old RAM value.
  - Undefined: `wr_mask` is ignored, the write FIFO is 32 bits wide, and every write updates all four bytes.

## Structure
- Package `mcb_port_pkg` contains:
  - The CMD_WRITE, CMD_READ, CMD_WRITE_PC, CMD_READ_PC and CMD_REFRESH constants.
  - The executor state encoding (IDLE, WRITE, READ_WAIT, READ, REFRESH).
- Sub-module `mcb_port_fifo`: a parameterized single-clock synchronous FIFO (width, depth, show-ahead read, count output), instantiated three times.

## Test plan
- **Write then read back:** push 4 words 0x11111111..0x44444444, then cmd write bl=3 at addr 0x10, then cmd read bl=3 at 0x10. Expect `rd_count` to reach 4 and pops to return the same 4 words in order.
- **Command FIFO full:** issue 5 refresh commands on consecutive cycles with the executor busy. Expect `cmd_full`=1 after 4, the 5th dropped, and `wr_error`=1.
- **Read overflow:** read bl=63 twice with no pops. Expect `rd_count`=64, `rd_full`=1, `rd_overflow`=1, and the head word equal to RAM[addr].
- **Write underrun and address wrap:** with MEM_AW=10, write bl=1 at 0x3FF with an empty write FIFO. Expect RAM[0x3FF]=0, RAM[0x000]=0 and `wr_underrun`=1.
- **Byte mask** (`MCB_PORT_WR_MASK_EN`): preload 0xAABBCCDD, then write 0x11223344 with mask 4'b0101. Read back 0x11BB33DD.
- **Reset mid-read:** assert `rst` during READ with `rd_count`=10. Expect all counts 0, all empties 1, and the FSM in IDLE; a subsequent read returns the RAM data intact.
